// File: rtl/spi_slave_burst_pkg.sv
// Shared types for the burst-capable SPI slave memory front end.
package spi_slave_burst_pkg;

    localparam int CMD_W = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        EXEC,
        WAIT,
        SEND,
        DONE
    } state_t;

endpackage

// File: rtl/spi_tx_serializer.sv
// MSB-first read-data serializer; miso is forced low whenever no word is in flight.
module spi_tx_serializer
    import spi_slave_burst_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic              enable,
    output logic              miso,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              active;

    assign done = active && enable && (cnt == CNT_W'(DATA_W - 1));
    assign miso = active & shreg[DATA_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg  <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (clear) begin
            shreg  <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            shreg  <= data;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active && enable) begin
            shreg <= shreg << 1;
            cnt   <= cnt + CNT_W'(1);
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_slave_burst.sv
// SPI slave decoding framed commands into single-port memory requests.
// Optional SPI_SLAVE_BURST_AUTOINC_EN: post-increment wr_addr/rd_addr after each data access.
module spi_slave_burst
    import spi_slave_burst_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy,
    output logic              frame_abort
);

    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int BIT_W   = $clog2(FRAME_W + 1);

    state_t            state;
    logic [FRAME_W-1:0] shift;
    logic [BIT_W-1:0]   bit_cnt;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  rd_addr;

    cmd_t              cmd;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] pay_addr;
    logic              abort_now;
    logic              tx_load;
    logic              tx_enable;
    logic              tx_done;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        if (32'(a) == MEM_DEPTH - 1) begin
            return '0;
        end
        return a + ADDR_W'(1);
    endfunction

    assign cmd       = cmd_t'(shift[FRAME_W-1 -: CMD_W]);
    assign payload   = shift[DATA_W-1:0];
    assign pay_addr  = ADDR_W'(32'(payload[ADDR_W-1:0]) % 32'(MEM_DEPTH));
    // EXEC is deliberately absent: its action commits even if ss_n rises.
    assign abort_now = ss_n && (state == RECV || state == WAIT || state == SEND);
    assign tx_load   = (state == WAIT) && !ss_n && mem_rvalid;
    assign tx_enable = (state == SEND) && !ss_n;
    assign busy      = (state != IDLE);

    spi_tx_serializer #(
        .DATA_W(DATA_W)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .clear (abort_now),
        .load  (tx_load),
        .data  (mem_rdata),
        .enable(tx_enable),
        .miso  (miso),
        .done  (tx_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            frame_abort <= 1'b0;
            if (abort_now) begin
                state       <= IDLE;
                frame_abort <= 1'b1;
                shift       <= '0;
                bit_cnt     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!ss_n) begin
                            state   <= RECV;
                            bit_cnt <= '0;
                        end
                    end
                    RECV: begin
                        shift   <= {shift[FRAME_W-2:0], mosi};
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                            state <= EXEC;
                        end
                    end
                    EXEC: begin
                        case (cmd)
                            CMD_WR_ADDR: begin
                                wr_addr <= pay_addr;
                                state   <= DONE;
                            end
                            CMD_WR_DATA: begin
                                mem_addr  <= wr_addr;
                                mem_wdata <= payload;
                                mem_we    <= 1'b1;
`ifdef SPI_SLAVE_BURST_AUTOINC_EN
                                wr_addr   <= addr_inc(wr_addr);
`endif
                                state     <= DONE;
                            end
                            CMD_RD_ADDR: begin
                                rd_addr <= pay_addr;
                                state   <= DONE;
                            end
                            CMD_RD_DATA: begin
                                mem_addr <= rd_addr;
                                mem_re   <= 1'b1;
`ifdef SPI_SLAVE_BURST_AUTOINC_EN
                                rd_addr  <= addr_inc(rd_addr);
`endif
                                state    <= WAIT;
                            end
                        endcase
                    end
                    WAIT: begin
                        if (mem_rvalid) begin
                            state <= SEND;
                        end
                    end
                    SEND: begin
                        if (tx_done) begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        if (ss_n) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_burst.sv
// Directed plus randomized bench for spi_slave_burst against a transaction-level model.
module tb_spi_slave_burst;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ss_n = 1'b1;
    logic          mosi = 1'b0;
    logic          miso;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rvalid = 1'b0;
    logic          busy;
    logic          frame_abort;

    spi_slave_burst #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi), .miso(miso),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // memory seen by the DUT, and the model's own view of what it should hold
    logic [DW-1:0] mem_tb  [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [AW-1:0] m_wr = '0;
    logic [AW-1:0] m_rd = '0;
    int            exp_aborts = 0;

    logic [AW-1:0] we_addr_q[$];
    logic [DW-1:0] we_data_q[$];
    logic [AW-1:0] re_addr_q[$];
    int            abort_cnt = 0;
    int            overlap_cnt = 0;
    int            rd_latency = 1;
    int            lat_cnt = 0;
    logic [AW-1:0] lat_addr = '0;

    always @(negedge clk) begin
        if (mem_we) begin
            we_addr_q.push_back(mem_addr);
            we_data_q.push_back(mem_wdata);
            mem_tb[mem_addr] = mem_wdata;
        end
        if (mem_re) re_addr_q.push_back(mem_addr);
        if (mem_we && mem_re) overlap_cnt++;
        if (frame_abort) abort_cnt++;
        mem_rvalid = 1'b0;
        if (rst) begin
            lat_cnt = 0;
        end else begin
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_tb[lat_addr];
                end
            end
            if (mem_re) begin
                lat_cnt  = rd_latency;
                lat_addr = mem_addr;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a);
        return AW'((int'(a) + 1) % DEPTH);
    endfunction

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [1:0] cmd, input logic [DW-1:0] pay, input int nbits);
        logic [DW+1:0] f;
        f = {cmd, pay};
        ss_n = 1'b0;
        mosi = 1'($urandom_range(0, 1));
        tick();
        for (int i = 0; i < nbits; i++) begin
            mosi = f[DW+1-i];
            tick();
        end
    endtask

    task automatic end_frame;
        ss_n = 1'b1;
        mosi = 1'b0;
        tick();
        tick();
    endtask

    task automatic clear_q;
        we_addr_q.delete();
        we_data_q.delete();
        re_addr_q.delete();
    endtask

    task automatic do_wr_addr(input logic [DW-1:0] a);
        send_bits(2'b00, a, DW + 2);
        mosi = 1'($urandom_range(0, 1));
        tick();
        end_frame();
        m_wr = AW'(int'(a[AW-1:0]) % DEPTH);
    endtask

    task automatic do_rd_addr(input logic [DW-1:0] a);
        send_bits(2'b10, a, DW + 2);
        tick();
        end_frame();
        m_rd = AW'(int'(a[AW-1:0]) % DEPTH);
    endtask

    task automatic do_wr_data(input logic [DW-1:0] d, input string tag);
        clear_q();
        send_bits(2'b01, d, DW + 2);
        mosi = 1'($urandom_range(0, 1));
        tick();
        tick();
        tick();
        end_frame();
        chk({tag, "_we_count"}, we_addr_q.size(), 1);
        if (we_addr_q.size() > 0) begin
            chk({tag, "_we_addr"}, we_addr_q[0], m_wr);
            chk({tag, "_we_data"}, we_data_q[0], d);
        end
        chk({tag, "_no_re"}, re_addr_q.size(), 0);
        ref_mem[m_wr] = d;
`ifdef SPI_SLAVE_BURST_AUTOINC_EN
        m_wr = nxt(m_wr);
`endif
    endtask

    task automatic do_rd_data(input int lat, input int rst_at, input string tag);
        logic [DW-1:0] exp;
        int w;
        exp = ref_mem[m_rd];
        rd_latency = lat;
        clear_q();
        send_bits(2'b11, DW'($urandom), DW + 2);
        w = 0;
        while (mem_rvalid !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        chk({tag, "_rvalid_seen"}, mem_rvalid, 1);
        chk({tag, "_re_count"}, re_addr_q.size(), 1);
        if (re_addr_q.size() > 0) chk({tag, "_re_addr"}, re_addr_q[0], m_rd);
        chk({tag, "_miso_wait"}, miso, 0);
        for (int i = 0; i < DW; i++) begin
            tick();
            chk($sformatf("%s_bit%0d", tag, i), miso, exp[DW-1-i]);
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                chk({tag, "_rst_miso"}, miso, 0);
                chk({tag, "_rst_busy"}, busy, 0);
                chk({tag, "_rst_re"}, mem_re, 0);
                chk({tag, "_rst_we"}, mem_we, 0);
                ss_n = 1'b1;
                #2;
                rst = 1'b0;
                m_wr = '0;
                m_rd = '0;
                tick();
                chk({tag, "_rst_idle"}, busy, 0);
                return;
            end
        end
        tick();
        chk({tag, "_miso_after"}, miso, 0);
        chk({tag, "_busy_done"}, busy, 1);
        end_frame();
        chk({tag, "_busy_idle"}, busy, 0);
`ifdef SPI_SLAVE_BURST_AUTOINC_EN
        m_rd = nxt(m_rd);
`endif
    endtask

    task automatic do_abort(input logic [1:0] cmd, input int k, input string tag);
        int n0;
        n0 = abort_cnt;
        clear_q();
        send_bits(cmd, DW'($urandom), k);
        ss_n = 1'b1;
        tick();
        chk({tag, "_pulse"}, frame_abort, 1);
        chk({tag, "_busy"}, busy, 0);
        tick();
        chk({tag, "_pulse_end"}, frame_abort, 0);
        chk({tag, "_count"}, abort_cnt, n0 + 1);
        chk({tag, "_no_mem"}, we_addr_q.size() + re_addr_q.size(), 0);
        exp_aborts++;
    endtask

    task automatic do_rd_race(input string tag);
        int w;
        int bad;
        rd_latency = 1;
        clear_q();
        send_bits(2'b11, DW'($urandom), DW + 2);
        w = 0;
        while (mem_rvalid !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        chk({tag, "_rvalid_seen"}, mem_rvalid, 1);
        ss_n = 1'b1;
        tick();
        chk({tag, "_pulse"}, frame_abort, 1);
        chk({tag, "_busy"}, busy, 0);
        bad = 0;
        for (int i = 0; i < DW + 2; i++) begin
            if (miso !== 1'b0) bad++;
            tick();
        end
        chk({tag, "_miso_low"}, bad, 0);
        exp_aborts++;
`ifdef SPI_SLAVE_BURST_AUTOINC_EN
        m_rd = nxt(m_rd);
`endif
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_tb[i]  = DW'($urandom);
            ref_mem[i] = mem_tb[i];
        end
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_miso", miso, 0);
        chk("rst_busy", busy, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_re", mem_re, 0);
        chk("rst_abort", frame_abort, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        rst = 1'b0;
        tick();

        do_wr_addr(8'h3C);
        do_wr_data(8'hA5, "wr");

        mem_tb[8'h10]  = 8'h5A;
        ref_mem[8'h10] = 8'h5A;
        do_rd_addr(8'h10);
        do_rd_data(1, -1, "rd");

        do_abort(2'b01, 5, "abort");
        do_wr_data(8'h77, "post_abort");

        do_wr_addr(8'hFF);
        do_wr_data(8'h11, "wrap0");
        do_wr_data(8'h22, "wrap1");
        do_wr_data(8'h33, "wrap2");

        do_rd_addr(8'h20);
        do_rd_data(2, 3, "rst_send");

        do_rd_addr(8'h40);
        do_rd_race("race");

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 5))
                0: do_wr_addr(DW'($urandom));
                1: do_wr_data(DW'($urandom), $sformatf("rnd%0d_wr", n));
                2: do_rd_addr(DW'($urandom));
                3, 5: do_rd_data(int'($urandom_range(1, 3)), -1, $sformatf("rnd%0d_rd", n));
                default: do_abort(2'($urandom_range(0, 3)), int'($urandom_range(1, DW + 1)),
                                  $sformatf("rnd%0d_ab", n));
            endcase
        end

        tick();
        chk("total_aborts", abort_cnt, exp_aborts);
        chk("we_re_overlap", overlap_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
